// File: rtl/q_8_40_pkg.sv
// q_8_40_pkg: shared types and constants for the q_8_40 multiplier host.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package q_8_40_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    LOAD,
    WAIT_RESULT,
    COLLECT,
    DONE
  } host_state_t;

  localparam int N_OP_BYTES   = 8;
  localparam int N_PROD_BYTES = 8;
  localparam int CALC_CYCLES  = 32;

  // Byte counter value of the final byte in either direction.
  localparam logic [2:0] LAST_BYTE = 3'd7;

endpackage

// File: rtl/q_8_40_host_if.sv
// q_8_40_host_if: byte-serial link between the host and a q_8_40 multiplier.
// Latency: n/a (wires only).
// Backpressure: rdy gates start; send_output qualifies each P byte.
// Signals: start/M host->multiplier, rdy/send_output/P multiplier->host.
interface q_8_40_host_if;
  logic       start;
  logic [7:0] M;
  logic       rdy;
  logic       send_output;
  logic [7:0] P;

  modport master (output start, M, input rdy, send_output, P);
  modport slave  (input start, M, output rdy, send_output, P);
endinterface

// File: rtl/q_8_40_host_ser.sv
// q_8_40_host_ser: operand shift-out register plus the shared 3-bit byte counter.
// Latency: ld takes effect next cycle; cur_byte is valid the cycle after ld.
// Backpressure: none; advances only when step is high.
// Ports: clk, rst_b; ld + op_a/op_b capture operands; step shifts one byte;
//        cur_byte is the byte to drive, byte_cntr the current byte index.
module q_8_40_host_ser (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        ld,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        step,
  output logic [7:0]  cur_byte,
  output logic [2:0]  byte_cntr
);

  logic [63:0] sreg;

  // op_a occupies the low half so bytes leave op_a LSB first, then op_b.
  // The counter keeps stepping during result collection; the register has
  // shifted empty by then, so the extra shifts are harmless.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sreg      <= '0;
      byte_cntr <= '0;
    end else if (ld) begin
      sreg      <= {op_b, op_a};
      byte_cntr <= '0;
    end else if (step) begin
      sreg      <= {8'h00, sreg[63:8]};
      byte_cntr <= byte_cntr + 3'd1;
    end
  end

  assign cur_byte = sreg[7:0];

endmodule

// File: rtl/q_8_40_host.sv
// q_8_40_host: serializes two 32-bit operands to a q_8_40 and gathers its 64-bit product.
// Latency: 1 cycle accept, rdy wait, 8 load cycles, calc wait, 8 collect cycles, 1 done cycle.
// Backpressure: req taken only in IDLE (no queuing); load waits for rdy; collection follows send_output.
// Ports: clk, rst_b; client req/op_a/op_b in, busy/done/err/product out;
//        mul (master) carries start/M out and rdy/send_output/P in.
module q_8_40_host #(
  parameter int TIMEOUT = 64,  // max WAIT_RESULT cycles before err
  parameter int CNTR_W  = 7    // 2**CNTR_W must exceed TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 req,
  input  logic [31:0]          op_a,
  input  logic [31:0]          op_b,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [63:0]          product,
  q_8_40_host_if.master        mul
);
  import q_8_40_pkg::*;

  localparam logic [CNTR_W-1:0] TMR_LAST = CNTR_W'(TIMEOUT - 1);

  host_state_t       state, state_nxt;
  logic [CNTR_W-1:0] tmr;
  logic [2:0]        byte_cntr;
  logic [7:0]        cur_byte;
  logic              ld, step, tmr_clr, tmr_inc, err_nxt, prod_we;

  q_8_40_host_ser u_ser (
    .clk       (clk),
    .rst_b     (rst_b),
    .ld        (ld),
    .op_a      (op_a),
    .op_b      (op_b),
    .step      (step),
    .cur_byte  (cur_byte),
    .byte_cntr (byte_cntr)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // The byte counter wraps 7->0 on the LOAD exit edge, so it is already 0
  // when the first product byte arrives in WAIT_RESULT.
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    step      = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    err_nxt   = 1'b0;
    prod_we   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          ld        = 1'b1;
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (mul.rdy) state_nxt = LOAD;
      end
      LOAD: begin
        step = 1'b1;
        if (byte_cntr == LAST_BYTE) begin
          tmr_clr   = 1'b1;
          state_nxt = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        // A first byte on the final allowed cycle still wins over the timeout.
        if (mul.send_output) begin
          prod_we   = 1'b1;
          step      = 1'b1;
          state_nxt = COLLECT;
        end else if (tmr == TMR_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      COLLECT: begin
        if (mul.send_output) begin
          prod_we = 1'b1;
          step    = 1'b1;
          if (byte_cntr == LAST_BYTE) state_nxt = DONE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // WAIT_RESULT spans TIMEOUT cycles; err rises TIMEOUT edges after byte 7 is taken.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)       tmr <= '0;
    else if (tmr_clr) tmr <= '0;
    else if (tmr_inc) tmr <= tmr + CNTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) err <= 1'b0;
    else        err <= err_nxt;
  end

  // Bytes land in place as they arrive; an aborted collection leaves a partial result.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)       product <= '0;
    else if (prod_we) product[{byte_cntr, 3'b000} +: 8] <= mul.P;
  end

  assign busy      = (state == WAIT_RDY) || (state == LOAD) ||
                     (state == WAIT_RESULT) || (state == COLLECT);
  assign done      = (state == DONE);
  assign mul.start = (state == LOAD) && (byte_cntr == 3'd0);
  assign mul.M     = (state == LOAD) ? cur_byte : 8'h00;

endmodule

// File: tb/tb_q_8_40_host.sv
// tb_q_8_40_host: host against a behavioural q_8_40 responder with random operands.
// Latency: responder computes the product CALC_CYCLES after the last operand byte.
// Backpressure: responder knobs rdy_block and resp_n stall rdy or cut the product stream.
module tb_q_8_40_host;
  import q_8_40_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int BUDGET  = 400;

  logic        clk   = 1'b0;
  logic        rst_b = 1'b0;
  logic        req   = 1'b0;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;
  logic        busy, done, err;
  logic [63:0] product;

  q_8_40_host_if mul ();

  q_8_40_host #(.TIMEOUT(TIMEOUT), .CNTR_W(7)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .req     (req),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .product (product),
    .mul     (mul)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Responder knobs and observations.
  int         rdy_block = 0;             // nonzero: hold rdy low while idle
  int         resp_n    = N_PROD_BYTES;  // product bytes to send (0 = never)
  logic [7:0] m_log[$];
  logic       s_log[$];
  int         l7_cyc = 0;

  // Behavioural multiplier: takes 8 operand bytes from the start edge on,
  // multiplies, then streams the product LSB byte first.
  initial begin : responder
    int          phase;
    int          cnt;
    logic [63:0] ops;
    logic [63:0] prod;
    phase = 0; cnt = 0; ops = '0; prod = '0;
    mul.rdy = 1'b1; mul.send_output = 1'b0; mul.P = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_b) begin
        phase = 0;
        mul.rdy = 1'b1; mul.send_output = 1'b0; mul.P = 8'h00;
      end else begin
        case (phase)
          0: begin
            mul.rdy = (rdy_block == 0);
            if (mul.start) begin
              ops = {56'h0, mul.M};
              m_log.push_back(mul.M);
              s_log.push_back(mul.start);
              cnt = 1; phase = 1; mul.rdy = 1'b0;
            end
          end
          1: begin
            ops[8*cnt +: 8] = mul.M;
            m_log.push_back(mul.M);
            s_log.push_back(mul.start);
            cnt++;
            if (cnt == N_OP_BYTES) begin
              prod   = {32'h0, ops[31:0]} * {32'h0, ops[63:32]};
              l7_cyc = cyc;
              cnt = 0; phase = 2;
            end
          end
          2: begin
            cnt++;
            if (cnt == CALC_CYCLES) begin
              if (resp_n == 0) begin
                phase = 0; mul.rdy = (rdy_block == 0);
              end else begin
                mul.send_output = 1'b1; mul.P = prod[7:0];
                cnt = 1; phase = 3;
              end
            end
          end
          3: begin
            if (cnt == resp_n) begin
              mul.send_output = 1'b0; mul.P = 8'h00;
              phase = 0; mul.rdy = (rdy_block == 0);
            end else begin
              mul.P = prod[8*cnt +: 8];
              cnt++;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // Issue one request and watch until the host is idle again after done/err.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit req_on_done,
                        output int nd, output int ne, output int ec,
                        output bit bwd, output bit fin);
    nd = 0; ne = 0; ec = -1; bwd = 1'b0; fin = 1'b0;
    m_log.delete(); s_log.delete();
    @(negedge clk);
    op_a = a; op_b = b; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < BUDGET && !fin; i++) begin
      if (done) begin nd++; if (busy) bwd = 1'b1; end
      if (err) begin if (ne == 0) ec = cyc; ne++; end
      req = (done && req_on_done);
      if (!busy && !done && !err && (nd + ne) > 0) fin = 1'b1;
      else @(negedge clk);
    end
    req = 1'b0;
  endtask

  task automatic pack_log(output logic [63:0] m, output logic [7:0] s);
    m = 'x; s = 'x;
    for (int i = 0; i < m_log.size() && i < N_OP_BYTES; i++) begin
      m[8*i +: 8] = m_log[i];
      s[i]        = s_log[i];
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, mul.start} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {busy, done, err, mul.start});
    end
    checks++;
    if (mul.M !== 8'h00) begin errors++; $display("FAIL reset_M got %h want 00", mul.M); end
    checks++;
    if (product !== 64'h0) begin errors++; $display("FAIL reset_product got %h want 0", product); end
    rst_b = 1'b1;
  endtask

  task automatic test_small();
    int nd, ne, ec; bit bwd, fin;
    logic [63:0] gm; logic [7:0] gs;
    resp_n = N_PROD_BYTES;
    run_op(32'h000000AA, 32'h00000003, 1'b0, nd, ne, ec, bwd, fin);
    pack_log(gm, gs);
    checks++;
    if (gm !== 64'h00000003_000000AA) begin errors++; $display("FAIL small_mseq got %h want 00000003000000aa", gm); end
    checks++;
    if (gs !== 8'b0000_0001) begin errors++; $display("FAIL small_start got %b want 00000001", gs); end
    checks++;
    if (product !== 64'h00000000000001FE) begin errors++; $display("FAIL small_product got %h want 1fe", product); end
    checks++;
    if (!fin || nd != 1 || ne != 0) begin errors++; $display("FAIL small_status got fin=%0d done=%0d err=%0d want 1 1 0", fin, nd, ne); end
    checks++;
    if (bwd) begin errors++; $display("FAIL small_busy_done got busy=1 during done want 0"); end
  endtask

  task automatic test_full();
    int nd, ne, ec; bit bwd, fin;
    logic [31:0] a, b;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    run_op(a, b, 1'b0, nd, ne, ec, bwd, fin);
    checks++;
    if (product !== {32'h0, a} * {32'h0, b}) begin errors++; $display("FAIL full_product got %h want %h", product, {32'h0, a} * {32'h0, b}); end
    checks++;
    if (!fin || nd != 1 || ne != 0) begin errors++; $display("FAIL full_status got fin=%0d done=%0d err=%0d want 1 1 0", fin, nd, ne); end
  endtask

  task automatic test_rdy_delay();
    logic [31:0] a, b;
    int bad, nd, ne; bit seen, fin;
    a = $urandom; b = $urandom;
    @(negedge clk);
    rdy_block = 1; op_a = a; op_b = b; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || mul.start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rdy_hold got %0d bad cycles want 0", bad); end
    rdy_block = 0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (mul.rdy) seen = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (mul.start !== 1'b1 || mul.M !== a[7:0]) begin
      errors++; $display("FAIL rdy_load_start got start=%b M=%h want 1 %h", mul.start, mul.M, a[7:0]);
    end
    nd = 0; ne = 0; fin = 1'b0;
    for (int i = 0; i < BUDGET && !fin; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (err) ne++;
      if (!busy && !done && (nd + ne) > 0) fin = 1'b1;
    end
    checks++;
    if (!fin || nd != 1 || ne != 0 || product !== {32'h0, a} * {32'h0, b}) begin
      errors++; $display("FAIL rdy_result got fin=%0d done=%0d err=%0d prod=%h want 1 1 0 %h", fin, nd, ne, product, {32'h0, a} * {32'h0, b});
    end
  endtask

  task automatic test_timeout();
    int nd, ne, ec; bit bwd, fin;
    logic [63:0] prior;
    prior  = product;
    resp_n = 0;
    run_op($urandom, $urandom, 1'b0, nd, ne, ec, bwd, fin);
    resp_n = N_PROD_BYTES;
    checks++;
    if (!fin || ne != 1 || nd != 0) begin errors++; $display("FAIL timeout_status got fin=%0d err=%0d done=%0d want 1 1 0", fin, ne, nd); end
    // byte 7 is taken at the edge ending its cycle; err rises TIMEOUT edges later
    checks++;
    if (ec - l7_cyc != TIMEOUT + 1) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", ec - l7_cyc, TIMEOUT + 1); end
    checks++;
    if (product !== prior) begin errors++; $display("FAIL timeout_product got %h want %h", product, prior); end
  endtask

  task automatic test_gap();
    int nd, ne, ec; bit bwd, fin;
    logic [31:0] a, b;
    logic [63:0] prior, full;
    a = $urandom; b = $urandom;
    prior  = product;
    full   = {32'h0, a} * {32'h0, b};
    resp_n = 5;
    run_op(a, b, 1'b0, nd, ne, ec, bwd, fin);
    resp_n = N_PROD_BYTES;
    checks++;
    if (!fin || ne != 1 || nd != 0) begin errors++; $display("FAIL gap_status got fin=%0d err=%0d done=%0d want 1 1 0", fin, ne, nd); end
    checks++;
    if (product !== {prior[63:40], full[39:0]}) begin errors++; $display("FAIL gap_partial got %h want %h", product, {prior[63:40], full[39:0]}); end
  endtask

  task automatic test_reset_mid();
    int nd, ne, ec; bit bwd, fin, seen;
    logic [31:0] a;
    a = $urandom;
    @(negedge clk);
    op_a = a; op_b = $urandom; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mul.start) seen = 1'b1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || mul.M !== a[31:24]) begin errors++; $display("FAIL rstmid_byte3 got seen=%0d M=%h want 1 %h", seen, mul.M, a[31:24]); end
    #1 rst_b = 1'b0;
    #1;
    checks++;
    if ({mul.start, busy, mul.M} !== 10'h000) begin errors++; $display("FAIL rstmid_async got start=%b busy=%b M=%h want 0 0 00", mul.start, busy, mul.M); end
    checks++;
    if (product !== 64'h0) begin errors++; $display("FAIL rstmid_product got %h want 0", product); end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    run_op(32'h12345678, 32'h00000010, 1'b0, nd, ne, ec, bwd, fin);
    checks++;
    if (!fin || nd != 1 || product !== 64'h0000000123456780) begin
      errors++; $display("FAIL rstmid_fresh got fin=%0d done=%0d prod=%h want 1 1 0000000123456780", fin, nd, product);
    end
  endtask

  task automatic test_random();
    int nd, ne, ec, stray; bit bwd, fin, rod;
    logic [31:0] a, b;
    logic [63:0] gm; logic [7:0] gs;
    for (int k = 0; k < 6; k++) begin
      a = $urandom; b = $urandom; rod = 1'($urandom_range(0, 1));
      run_op(a, b, rod, nd, ne, ec, bwd, fin);
      pack_log(gm, gs);
      checks++;
      if (product !== {32'h0, a} * {32'h0, b}) begin errors++; $display("FAIL rand_product[%0d] got %h want %h", k, product, {32'h0, a} * {32'h0, b}); end
      checks++;
      if (gm !== {b, a} || gs !== 8'b0000_0001) begin errors++; $display("FAIL rand_mseq[%0d] got %h/%b want %h/00000001", k, gm, gs, {b, a}); end
      checks++;
      if (!fin || nd != 1 || ne != 0 || bwd) begin errors++; $display("FAIL rand_status[%0d] got fin=%0d done=%0d err=%0d bwd=%0d want 1 1 0 0", k, fin, nd, ne, bwd); end
      if (rod) begin
        stray = 0;
        repeat (3) begin @(negedge clk); if (busy) stray++; end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rand_req_in_done[%0d] got %0d busy cycles want 0", k, stray); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_full();
    test_rdy_delay();
    test_timeout();
    test_gap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
